// File: rtl/mem_map_pkg.sv
// Address map constants, ROM image and region decode shared by the memory responder.
package mem_map_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int ROM_DEPTH = 128;
    localparam int ROM_AW    = 7;

    localparam logic [ADDR_W-1:0] ROM_BASE        = 8'h00;
    localparam logic [ADDR_W-1:0] RAM_BASE_DEF    = 8'h80;
    localparam logic [ADDR_W-1:0] IO_BASE_DEF     = 8'hE0;
    localparam logic [ADDR_W-1:0] PORT_OUT_A_ADDR = 8'hE0;
    localparam logic [ADDR_W-1:0] PORT_OUT_B_ADDR = 8'hE1;
    localparam logic [ADDR_W-1:0] PORT_IN_A_ADDR  = 8'hF0;
    localparam logic [ADDR_W-1:0] PORT_IN_B_ADDR  = 8'hF1;

    typedef logic [ROM_DEPTH-1:0][DATA_W-1:0] rom_t;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_OUT_A,
        REG_OUT_B,
        REG_IN_A,
        REG_IN_B,
        REG_NONE
    } region_e;

    // Fixed image: entry i holds (37*i + 0x86) mod 256, so location 0 is 0x86.
    function automatic rom_t build_rom();
        rom_t rom;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            rom[i] = 8'((i * 37) + 134);
        end
        return rom;
    endfunction

    localparam rom_t ROM_INIT = build_rom();

    function automatic region_e decode_addr(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] ram_base,
                                            input logic [ADDR_W-1:0] io_base);
        region_e region;
        if (addr < ram_base) begin
            region = REG_ROM;
        end else if (addr < io_base) begin
            region = REG_RAM;
        end else begin
            case (addr)
                PORT_OUT_A_ADDR: region = REG_OUT_A;
                PORT_OUT_B_ADDR: region = REG_OUT_B;
                PORT_IN_A_ADDR:  region = REG_IN_A;
                PORT_IN_B_ADDR:  region = REG_IN_B;
                default:         region = REG_NONE;
            endcase
        end
        return region;
    endfunction

endpackage

// File: rtl/sync2.sv
// 8-bit two-flop synchronizer for asynchronous external inputs.
module sync2
    import mem_map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_meta;
    logic [DATA_W-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/memory_responder.sv
// Memory-mapped responder: MAR, ROM, RAM, output ports and synchronized input ports
// behind a single registered read-data path.
module memory_responder
    import mem_map_pkg::*;
#(
    parameter logic [7:0] RAM_BASE = RAM_BASE_DEF,
    parameter logic [7:0] IO_BASE  = IO_BASE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mar_load,
    input  logic [7:0] address_in,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic [7:0] data_out,
    input  logic [7:0] port_in_a,
    input  logic [7:0] port_in_b,
    output logic [7:0] port_out_a,
    output logic [7:0] port_out_b,
    input  logic       fault_clr,
    output logic       write_fault
);

    localparam int RAM_DEPTH = int'(IO_BASE) - int'(RAM_BASE);
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    logic [7:0]        r_ram [0:RAM_DEPTH-1];
    logic [7:0]        r_mar;
    logic [7:0]        r_data_out;
    logic [7:0]        r_port_out_a;
    logic [7:0]        r_port_out_b;
    logic              r_write_fault;
    logic              r_wr_armed;

    logic [7:0]        w_sync_a;
    logic [7:0]        w_sync_b;
    logic [7:0]        w_rd_data;
    region_e           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [ROM_AW-1:0] w_rom_idx;
    logic              w_ram_we;
    logic              w_illegal_wr;

    sync2 u_sync_a (
        .clk   (clk),
        .reset (reset),
        .i_d   (port_in_a),
        .o_q   (w_sync_a)
    );

    sync2 u_sync_b (
        .clk   (clk),
        .reset (reset),
        .i_d   (port_in_b),
        .o_q   (w_sync_b)
    );

    assign w_region  = decode_addr(r_mar, RAM_BASE, IO_BASE);
    assign w_ram_idx = RAM_AW'(r_mar - RAM_BASE);
    assign w_rom_idx = ROM_AW'(r_mar - ROM_BASE);

    always_comb begin
        w_rd_data = 8'h00;
        case (w_region)
            REG_ROM:   w_rd_data = ROM_INIT[w_rom_idx];
            REG_RAM:   w_rd_data = r_ram[w_ram_idx];
            REG_OUT_A: w_rd_data = r_port_out_a;
            REG_OUT_B: w_rd_data = r_port_out_b;
            REG_IN_A:  w_rd_data = w_sync_a;
            REG_IN_B:  w_rd_data = w_sync_b;
            default:   w_rd_data = 8'h00;
        endcase
    end

    assign w_ram_we     = write && r_wr_armed && (w_region == REG_RAM);
    assign w_illegal_wr = write && (w_region == REG_ROM  || w_region == REG_IN_A ||
                                    w_region == REG_IN_B || w_region == REG_NONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mar      <= 8'h00;
            r_data_out <= 8'h00;
        end else begin
            if (mar_load) begin
                r_mar <= address_in;
            end
            r_data_out <= w_rd_data;
        end
    end

    // RAM has no reset; the arm flag is cleared by reset so a write presented while
    // reset is held (or on the release edge) never lands in the array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_armed <= 1'b0;
        end else begin
            r_wr_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_out_a <= 8'h00;
            r_port_out_b <= 8'h00;
        end else if (write) begin
            if (w_region == REG_OUT_A) begin
                r_port_out_a <= data_in;
            end
            if (w_region == REG_OUT_B) begin
                r_port_out_b <= data_in;
            end
        end
    end

    // Set has priority over clear so a fault raised on the clearing edge is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write_fault <= 1'b0;
        end else if (w_illegal_wr) begin
            r_write_fault <= 1'b1;
        end else if (fault_clr) begin
            r_write_fault <= 1'b0;
        end
    end

    assign data_out    = r_data_out;
    assign port_out_a  = r_port_out_a;
    assign port_out_b  = r_port_out_b;
    assign write_fault = r_write_fault;

endmodule

// File: tb/tb_memory_responder.sv
// Scenario bench for memory_responder: expected read data is queued as stimulus is
// driven and popped when data_out is sampled.
module tb_memory_responder;

    logic       clk;
    logic       reset;
    logic       mar_load;
    logic [7:0] address_in;
    logic [7:0] data_in;
    logic       write;
    logic [7:0] data_out;
    logic [7:0] port_in_a;
    logic [7:0] port_in_b;
    logic [7:0] port_out_a;
    logic [7:0] port_out_b;
    logic       fault_clr;
    logic       write_fault;

    int         total;
    int         bad;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    memory_responder dut (
        .clk         (clk),
        .reset       (reset),
        .mar_load    (mar_load),
        .address_in  (address_in),
        .data_in     (data_in),
        .write       (write),
        .data_out    (data_out),
        .port_in_a   (port_in_a),
        .port_in_b   (port_in_b),
        .port_out_a  (port_out_a),
        .port_out_b  (port_out_b),
        .fault_clr   (fault_clr),
        .write_fault (write_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a);
        mar_load   = 1'b1;
        address_in = a;
        tick();
        mar_load   = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        write   = 1'b1;
        data_in = d;
        tick();
        write   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data_out got=%h want=00", data_out);
        end
        total++;
        if (port_out_a !== 8'h00 || port_out_b !== 8'h00) begin
            bad++;
            $display("FAIL reset_ports got=%h/%h want=00/00", port_out_a, port_out_b);
        end
        total++;
        if (write_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_fault got=%b want=0", write_fault);
        end
        reset = 1'b1;
        exp_q.push_back(8'h86);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL reset_first_fetch got=%h want=%h", data_out, exp_v);
        end
    endtask

    task automatic test_rom_read();
        logic [7:0] addrs [3];
        logic [7:0] vals  [3];
        addrs = '{8'h01, 8'h10, 8'h7F};
        vals  = '{8'hAB, 8'hD6, 8'hE1};
        for (int i = 0; i < 3; i++) begin
            load(addrs[i]);
            exp_q.push_back(vals[i]);
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (data_out !== exp_v) begin
                bad++;
                $display("FAIL rom_read addr=%h got=%h want=%h", addrs[i], data_out, exp_v);
            end
        end
    endtask

    task automatic test_ram_rw();
        load(8'h80);
        wr(8'h11);
        exp_q.push_back(8'h11);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL ram_first_write got=%h want=%h", data_out, exp_v);
        end
        exp_q.push_back(8'h11);
        wr(8'h5A);
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL ram_read_first got=%h want=%h", data_out, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h5A);
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (data_out !== exp_v) begin
                bad++;
                $display("FAIL ram_new_value idle=%0d got=%h want=%h", i, data_out, exp_v);
            end
        end
        load(8'hDF);
        wr(8'h3E);
        exp_q.push_back(8'h3E);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v || write_fault !== 1'b0) begin
            bad++;
            $display("FAIL ram_top got=%h fault=%b want=%h fault=0", data_out, write_fault, exp_v);
        end
    endtask

    task automatic test_rom_write_fault();
        load(8'h10);
        wr(8'hFF);
        total++;
        if (write_fault !== 1'b1) begin
            bad++;
            $display("FAIL rom_wr_fault got=%b want=1", write_fault);
        end
        exp_q.push_back(8'hD6);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL rom_unchanged got=%h want=%h", data_out, exp_v);
        end
        total++;
        if (write_fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_sticky got=%b want=1", write_fault);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++;
        if (write_fault !== 1'b0) begin
            bad++;
            $display("FAIL fault_clear got=%b want=0", write_fault);
        end
        fault_clr = 1'b1;
        wr(8'hFF);
        fault_clr = 1'b0;
        total++;
        if (write_fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_set_wins got=%b want=1", write_fault);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    task automatic test_port_out();
        load(8'hE0);
        wr(8'hC3);
        total++;
        if (port_out_a !== 8'hC3 || port_out_b !== 8'h00) begin
            bad++;
            $display("FAIL port_out_a_write got=%h/%h want=c3/00", port_out_a, port_out_b);
        end
        exp_q.push_back(8'hC3);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL port_out_a_read got=%h want=%h", data_out, exp_v);
        end
        load(8'hE1);
        wr(8'h99);
        total++;
        if (port_out_b !== 8'h99 || port_out_a !== 8'hC3 || write_fault !== 1'b0) begin
            bad++;
            $display("FAIL port_out_b_write got=%h/%h fault=%b want=c3/99 fault=0",
                     port_out_a, port_out_b, write_fault);
        end
        load(8'hE5);
        exp_q.push_back(8'h00);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL unmapped_read got=%h want=%h", data_out, exp_v);
        end
        wr(8'h12);
        total++;
        if (write_fault !== 1'b1 || port_out_a !== 8'hC3 || port_out_b !== 8'h99) begin
            bad++;
            $display("FAIL unmapped_write fault=%b ports=%h/%h want fault=1 ports=c3/99",
                     write_fault, port_out_a, port_out_b);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    task automatic test_port_in();
        logic [7:0] seq [3];
        seq = '{8'h00, 8'h00, 8'h3C};
        load(8'hF1);
        repeat (2) tick();
        port_in_b = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(seq[i]);
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (data_out !== exp_v) begin
                bad++;
                $display("FAIL port_in_b_latency edge=%0d got=%h want=%h", i + 1, data_out, exp_v);
            end
        end
        exp_q.push_back(8'h3C);
        wr(8'h55);
        exp_v = exp_q.pop_front();
        total++;
        if (write_fault !== 1'b1 || data_out !== exp_v) begin
            bad++;
            $display("FAIL port_in_write fault=%b data=%h want fault=1 data=%h",
                     write_fault, data_out, exp_v);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        port_in_a = 8'hA7;
        load(8'hF0);
        exp_q.push_back(8'hA7);
        repeat (2) tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL port_in_a_read got=%h want=%h", data_out, exp_v);
        end
    endtask

    task automatic test_same_edge();
        load(8'h81);
        wr(8'h22);
        load(8'h80);
        mar_load   = 1'b1;
        address_in = 8'h81;
        write      = 1'b1;
        data_in    = 8'h77;
        tick();
        mar_load   = 1'b0;
        write      = 1'b0;
        exp_q.push_back(8'h22);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL same_edge_new_mar got=%h want=%h", data_out, exp_v);
        end
        load(8'h80);
        exp_q.push_back(8'h77);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL same_edge_old_mar got=%h want=%h", data_out, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [8];
        logic [7:0] vals  [8];
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 8'(8'h90 + i * 9);
            vals[i]  = 8'($urandom_range(0, 255));
            load(addrs[i]);
            wr(vals[i]);
        end
        for (int i = 0; i < 8; i++) begin
            load(addrs[i]);
            exp_q.push_back(vals[i]);
            tick();
            exp_v = exp_q.pop_front();
            total++;
            if (data_out !== exp_v) begin
                bad++;
                $display("FAIL b2b_read addr=%h got=%h want=%h", addrs[i], data_out, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        load(8'hA0);
        wr(8'h44);
        reset = 1'b0;
        #1;
        total++;
        if (data_out !== 8'h00 || port_out_a !== 8'h00 || port_out_b !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%h ports=%h/%h want=00 ports=00/00",
                     data_out, port_out_a, port_out_b);
        end
        write   = 1'b1;
        data_in = 8'hBB;
        tick();
        write   = 1'b0;
        reset   = 1'b1;
        exp_q.push_back(8'h86);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v || write_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_refetch got=%h fault=%b want=%h fault=0", data_out, write_fault, exp_v);
        end
        load(8'hA0);
        exp_q.push_back(8'h44);
        tick();
        exp_v = exp_q.pop_front();
        total++;
        if (data_out !== exp_v) begin
            bad++;
            $display("FAIL reset_discard_write got=%h want=%h", data_out, exp_v);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        mar_load   = 1'b0;
        address_in = 8'h00;
        data_in    = 8'h00;
        write      = 1'b0;
        port_in_a  = 8'h00;
        port_in_b  = 8'h00;
        fault_clr  = 1'b0;

        test_reset();
        test_rom_read();
        test_ram_rw();
        test_rom_write_fault();
        test_port_out();
        test_port_in();
        test_same_edge();
        test_back_to_back();
        test_reset_mid_write();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter RAM_BASE, default 8'h80, meaning the first RAM address; 0x00..RAM_BASE-1 is ROM.
REQ-002 SHALL have parameter IO_BASE, default 8'hE0, meaning the first I/O address; RAM spans RAM_BASE..IO_BASE-1.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mar_load  input  1  capture address_in into MAR at the clock edge.
REQ-006 address_in  input  8  address from the Bus2 driver.
REQ-007 data_in  input  8  write data from the Bus1 driver.
REQ-008 write  input  1  write strobe; store data_in at MAR at the clock edge.
REQ-009 data_out  output  8  registered read data returned to Bus2.
REQ-010 port_in_a, port_in_b  input  8 each  asynchronous external inputs.
REQ-011 port_out_a, port_out_b  output  8 each  registered output ports.
REQ-012 fault_clr  input  1  synchronous clear of write_fault.
REQ-013 write_fault  output  1  sticky illegal-write flag.

Function
REQ-014 The 8-bit MAR SHALL load address_in on an edge with mar_load=1 and otherwise hold its value.
REQ-015 The address map SHALL be:
  - ROM: below RAM_BASE.
  - RAM: RAM_BASE..IO_BASE-1.
  - 0xE0/0xE1: port_out_a/b, read/write.
  - 0xF0/0xF1: port_in_a/b, read-only.
  - All other I/O addresses: unmapped, read as 0x00.
REQ-016 data_out SHALL update every edge from the location addressed by the current MAR (synchronous read).
  - An address loaded at edge N is visible on data_out after edge N+1.
  - This matches the fetch sequence MAR-load, wait, capture.
REQ-017 ROM contents SHALL come from the package constant array ROM_INIT and SHALL be read-only.
REQ-018 On an edge with write=1, data_in SHALL be stored at MAR if MAR is in RAM, 0xE0 or 0xE1.
REQ-019 A write to ROM, 0xF0/0xF1 or an unmapped address SHALL leave all storage unchanged and set write_fault=1.
REQ-020 Read-first rule: on the write edge, data_out SHALL take the old content; the new value appears one edge later.
REQ-021 Simultaneous write and mar_load SHALL write at the old MAR, and MAR SHALL then take address_in.
REQ-022 port_in_a/b SHALL each pass through a two-flop synchronizer; reads of 0xF0/0xF1 return the synchronized value.
  - Latency from port pin to data_out is 3 edges with MAR already pointing at the port.
REQ-023 Once set, write_fault SHALL hold until fault_clr=1; if an illegal write and fault_clr occur together, set wins.
REQ-024 port_out_a/b SHALL change only on a legal write to their address; reading them returns the current register value.

Reset
REQ-025 While reset=0, asynchronously:
  - MAR=0x00, data_out=0x00, port_out_a/b=0x00, write_fault=0, synchronizer flops=0x00.
REQ-026 RAM SHALL NOT be reset; its contents are undefined until written. Reset mid-write SHALL discard that write.
REQ-027 After reset release, the first edge SHALL present ROM_INIT[0] on data_out.

Structure
REQ-028 Package mem_map_pkg SHALL hold the ROM/RAM/IO base constants, the port addresses 0xE0/0xE1/0xF0/0xF1, and ROM_INIT.
REQ-029 Sub-module sync2 (8-bit two-flop synchronizer, async active-low reset) SHALL be instantiated once per input port.
REQ-030 RAM SHALL be a single inferred 96x8 array with one write port and one read port.

Verification
REQ-031 Reset release with ROM_INIT[0]=0x86 -> data_out=0x86 after edge 1.
REQ-032 mar_load with 0x80, then write 0x5A, then two idle edges -> data_out=0x5A; on the write edge data_out keeps the old value.
REQ-033 MAR=0x10, write=1, data_in=0xFF -> ROM unchanged, write_fault=1 until fault_clr=1; fault_clr with a simultaneous illegal write -> write_fault stays 1.
REQ-034 Write 0xC3 to 0xE0 -> port_out_a=0xC3 next edge, port_out_b=0x00; reading 0xE0 returns 0xC3.
REQ-035 port_in_b=0x3C with MAR=0xF1 -> data_out=0x3C exactly 3 edges later; a write to 0xF1 sets write_fault.
REQ-036 Same-edge mar_load(0x81) and write(0x77) with MAR=0x80 -> RAM[0x80]=0x77, RAM[0x81] unchanged, MAR=0x81.
